// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: one outstanding imem
// request, a one-entry hold buffer for decode stalls, and redirect handling.
module fetch_stage #(
  parameter int unsigned                DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]      RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0]      NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_d,
  input  logic                  flush_d,
  input  logic                  pc_src_e,
  input  logic [DATA_WIDTH-1:0] pc_target_e,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr_d,
  output logic [DATA_WIDTH-1:0] pc_d,
  output logic [DATA_WIDTH-1:0] pc_plus4_d,
  output logic                  valid_d
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   pc_req, redir_pc, buf_instr, buf_pc;
  logic                    issue, deliver, buf_load, redir_load;
  logic [DATA_WIDTH-1:0]   issue_addr, del_instr, del_pc;

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_addr = '0;
    deliver    = 1'b0;
    del_instr  = '0;
    del_pc     = '0;
    buf_load   = 1'b0;
    redir_load = 1'b0;
    case (state)
      IDLE: begin
        issue      = 1'b1;
        issue_addr = RESET_PC;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (pc_src_e) begin
          if (imem_rvalid) begin
            issue      = 1'b1;
            issue_addr = pc_target_e;
          end else begin
            redir_load = 1'b1;
            state_nxt  = DROP;
          end
        end else if (imem_rvalid) begin
          if (!stall_d) begin
            deliver    = 1'b1;
            del_instr  = imem_rdata;
            del_pc     = pc_req;
            issue      = 1'b1;
            issue_addr = pc_req + DATA_WIDTH'(4);
          end else begin
            buf_load  = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (pc_src_e) begin
          issue      = 1'b1;
          issue_addr = pc_target_e;
          state_nxt  = WAIT;
        end else if (!stall_d) begin
          deliver    = 1'b1;
          del_instr  = buf_instr;
          del_pc     = buf_pc;
          issue      = 1'b1;
          issue_addr = buf_pc + DATA_WIDTH'(4);
          state_nxt  = WAIT;
        end
      end
      DROP: begin
        // The response in flight belongs to the pre-redirect path; discard it.
        if (imem_rvalid) begin
          issue      = 1'b1;
          issue_addr = pc_src_e ? pc_target_e : redir_pc;
          state_nxt  = WAIT;
        end else if (pc_src_e) begin
          redir_load = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign imem_req  = issue & ~rst;
  assign imem_addr = issue_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc_req     <= '0;
      redir_pc   <= '0;
      buf_instr  <= '0;
      buf_pc     <= '0;
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (issue)      pc_req   <= issue_addr;
      if (redir_load) redir_pc <= pc_target_e;
      if (buf_load) begin
        buf_instr <= imem_rdata;
        buf_pc    <= pc_req;
      end
      if (flush_d) begin
        instr_d <= NOP_INSTR;
        valid_d <= 1'b0;
      end else if (stall_d) begin
        instr_d <= instr_d;
      end else if (deliver) begin
        instr_d    <= del_instr;
        pc_d       <= del_pc;
        pc_plus4_d <= del_pc + DATA_WIDTH'(4);
        valid_d    <= 1'b1;
      end else begin
        instr_d <= NOP_INSTR;
        valid_d <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand sequences
// for redirect/reset corners, and random traffic against a reference model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_d = 1'b0, flush_d = 1'b0, pc_src_e = 1'b0;
  logic [31:0] pc_target_e = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d;

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // memory model: one outstanding request, response = 0xAAAA0000 + addr
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;
  int          lat_lo = 1, lat_hi = 1;

  // reference model: fetch bookkeeping in terms of "started / buffered / stale"
  bit          m_started = 1'b0, m_buf = 1'b0, m_stale = 1'b0;
  logic [31:0] m_out_pc = '0, m_redir = '0, m_buf_pc = '0, m_buf_instr = '0;
  logic [31:0] m_instr = NOP, m_pc = '0, m_pc4 = '0;
  bit          m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit f, input bit p, input logic [31:0] t);
    bit          e_req, del;
    logic [31:0] e_addr, d_instr, d_pc;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (r) mem_busy = 1'b0;
    else if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hAAAA_0000 + mem_addr;
        mem_busy    = 1'b0;
      end
    end
    rst = r; stall_d = s; flush_d = f; pc_src_e = p; pc_target_e = t;
    #2;
    e_req = 1'b0; e_addr = '0; del = 1'b0; d_instr = '0; d_pc = '0;
    if (!r) begin
      if (!m_started) begin
        e_req = 1'b1; e_addr = RST_PC;
      end else if (m_buf) begin
        if (p) begin
          m_buf = 1'b0; e_req = 1'b1; e_addr = t;
        end else if (!s) begin
          m_buf = 1'b0; del = 1'b1; d_instr = m_buf_instr; d_pc = m_buf_pc;
          e_req = 1'b1; e_addr = m_buf_pc + 32'd4;
        end
      end else if (m_stale) begin
        if (imem_rvalid) begin
          m_stale = 1'b0; e_req = 1'b1; e_addr = p ? t : m_redir;
        end else if (p) m_redir = t;
      end else if (p) begin
        if (imem_rvalid) begin
          e_req = 1'b1; e_addr = t;
        end else begin
          m_stale = 1'b1; m_redir = t;
        end
      end else if (imem_rvalid) begin
        if (!s) begin
          del = 1'b1; d_instr = imem_rdata; d_pc = m_out_pc;
          e_req = 1'b1; e_addr = m_out_pc + 32'd4;
        end else begin
          m_buf = 1'b1; m_buf_instr = imem_rdata; m_buf_pc = m_out_pc;
        end
      end
    end
    check("imem_req", {31'd0, imem_req}, {31'd0, e_req});
    if (e_req) check("imem_addr", imem_addr, e_addr);
    if (imem_req && !r) check("one_outstanding", {31'd0, mem_busy}, 32'd0);
    check("instr_d", instr_d, m_instr);
    check("pc_d", pc_d, m_pc);
    check("pc_plus4_d", pc_plus4_d, m_pc4);
    check("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
    if (r) begin
      m_started = 1'b0; m_buf = 1'b0; m_stale = 1'b0;
      m_instr = NOP; m_pc = '0; m_pc4 = '0; m_valid = 1'b0;
    end else begin
      m_started = 1'b1;
      if (e_req) m_out_pc = e_addr;
      if (f) begin
        m_instr = NOP; m_valid = 1'b0;
      end else if (!s) begin
        if (del) begin
          m_instr = d_instr; m_pc = d_pc; m_pc4 = d_pc + 32'd4; m_valid = 1'b1;
        end else begin
          m_instr = NOP; m_valid = 1'b0;
        end
      end
    end
    if (imem_req && !r) begin
      mem_busy = 1'b1; mem_addr = imem_addr;
      mem_cnt  = (lat_lo == lat_hi) ? lat_lo : int'($urandom_range(lat_hi, lat_lo));
    end
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Step idle cycles until a request appears; an expired budget is a failure.
  task automatic wait_req(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      idle_step();
      seen = imem_req;
    end
    check({name, "_req_seen"}, {31'd0, seen}, 32'd1);
  endtask

  typedef struct {
    bit          rst;
    bit          stall;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int          nv;
    bit          saw4;
    logic [31:0] tv;

    // latency-1 streaming with a 2-cycle stall when the 0x8 response arrives
    tbl[0] = '{1, 0, 0, 32'h0,  0, 32'h0};
    tbl[1] = '{1, 0, 0, 32'h0,  0, 32'h0};
    tbl[2] = '{0, 0, 1, 32'h0,  0, 32'h0};
    tbl[3] = '{0, 0, 1, 32'h4,  0, 32'h0};
    tbl[4] = '{0, 0, 1, 32'h8,  1, 32'h0};
    tbl[5] = '{0, 1, 0, 32'h0,  1, 32'h4};
    tbl[6] = '{0, 1, 0, 32'h0,  1, 32'h4};
    tbl[7] = '{0, 0, 1, 32'hC,  1, 32'h4};
    tbl[8] = '{0, 0, 1, 32'h10, 1, 32'h8};
    tbl[9] = '{0, 0, 1, 32'h14, 1, 32'hC};

    lat_lo = 1; lat_hi = 1;
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].stall, 1'b0, 1'b0, 32'h0);
      check("tbl_req", {31'd0, imem_req}, {31'd0, tbl[i].req});
      if (tbl[i].req) check("tbl_addr", imem_addr, tbl[i].addr);
      check("tbl_valid", {31'd0, valid_d}, {31'd0, tbl[i].valid});
      check("tbl_pc", pc_d, tbl[i].pc);
      tv = tbl[i].valid ? 32'hAAAA_0000 + tbl[i].pc : NOP;
      check("tbl_instr", instr_d, tv);
      tv = tbl[i].valid ? tbl[i].pc + 32'd4 : 32'h0;
      check("tbl_pc4", pc_plus4_d, tv);
    end

    // latency 3: one delivery every third cycle
    lat_lo = 3; lat_hi = 3;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      idle_step();
      if (valid_d) nv++;
    end
    check("lat3_valid_count", nv, 32'd3);

    // redirect one cycle after the request to 0x4; that response is dropped
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) idle_step();
    check("redir_prior_addr", imem_addr, 32'h4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
    wait_req("redir");
    check("redir_addr", imem_addr, 32'h100);
    saw4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle_step();
      if (valid_d && pc_d == 32'h4) saw4 = 1'b1;
    end
    check("stale_pc4_never_valid", {31'd0, saw4}, 32'd0);

    // redirect coinciding with rvalid, then a second redirect while dropping
    lat_lo = 1; lat_hi = 1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    idle_step();
    lat_lo = 3; lat_hi = 3;
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
    check("same_cycle_redir_req", {31'd0, imem_req}, 32'd1);
    check("same_cycle_redir_addr", imem_addr, 32'h200);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h250);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h300);
    wait_req("drop_redir");
    check("drop_redir_addr", imem_addr, 32'h300);

    // reset while a request is outstanding
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) idle_step();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("rst_req_low", {31'd0, imem_req}, 32'd0);
    idle_step();
    check("post_rst_valid", {31'd0, valid_d}, 32'd0);
    check("post_rst_instr", instr_d, NOP);
    check("post_rst_pc", pc_d, 32'h0);
    check("post_rst_pc4", pc_plus4_d, 32'h0);
    check("post_rst_req", {31'd0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, RST_PC);

    // random traffic against the model
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 2000; i++) begin
      bit r, s, f, p;
      logic [31:0] t;
      r = ($urandom_range(99) == 0);
      s = ($urandom_range(99) < 30);
      p = ($urandom_range(99) < 8);
      f = p | ($urandom_range(99) < 5);
      t = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(19) == 0) t = 32'hFFFF_FFFC;
      step(r, s, f, p, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the decode stage and feeds it instr_d, pc_d and pc_plus4_d.
- Talks to a variable-latency instruction memory through a req/rvalid interface with one request outstanding.
- Handles decode back-pressure using a one-entry hold buffer.
- Handles branch/jump redirects from execute, including discarding stale in-flight responses.

Parameters:
DATA_WIDTH, 32, width of instructions and addresses
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall_d  in  1  decode cannot accept; IF/ID holds
flush_d  in  1  load bubble into IF/ID
pc_src_e  in  1  redirect request from execute (taken branch/jump)
pc_target_e  in  DATA_WIDTH  redirect target
imem_req  out  1  request strobe; memory accepts the same cycle
imem_addr  out  DATA_WIDTH  request address, valid when imem_req=1
imem_rvalid  in  1  response valid
imem_rdata  in  DATA_WIDTH  response instruction
instr_d  out  DATA_WIDTH  IF/ID instruction
pc_d  out  DATA_WIDTH  IF/ID PC
pc_plus4_d  out  DATA_WIDTH  IF/ID PC+4
valid_d  out  1  IF/ID holds a real instruction

Behaviour:
Reset and interface basics:
- Reset (rst=1, any state): state=IDLE, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, hold buffer empty, imem_req=0.
- imem_req and imem_addr are combinational from state and inputs. imem_req is forced to 0 while rst=1.

Memory contract:
- Exactly one response per request.
- Response latency is at least 1 cycle.
- imem_rvalid is never asserted with no request outstanding.
- imem_rvalid is ignored in IDLE and HOLD.

Internal registers:
- pc_req: address of the outstanding or buffered request.
- redir_pc: pending redirect target.
- buf_instr, buf_pc: hold buffer contents.

Issuing a request:
- "Issue X" means imem_req=1, imem_addr=X, pc_req<=X for that cycle.

States and transitions (evaluate in the order listed):
- IDLE: issue RESET_PC, go to WAIT.
- WAIT, with pc_src_e=1 and rvalid=1: discard rdata, issue pc_target_e, stay in WAIT.
- WAIT, with pc_src_e=1 and rvalid=0: redir_pc<=pc_target_e, go to DROP.
- WAIT, with rvalid=1 and stall_d=0: deliver rdata with pc_req, issue pc_req+4, stay in WAIT. This gives back-to-back throughput of 1 instruction/cycle at latency 1.
- WAIT, with rvalid=1 and stall_d=1: buf<=(rdata, pc_req), go to HOLD, no request.
- HOLD, with pc_src_e=1: drop the buffer, issue pc_target_e, go to WAIT.
- HOLD, with stall_d=0: deliver the buffer, issue buf_pc+4, go to WAIT.
- HOLD, otherwise: stay in HOLD, no request.
- DROP, with rvalid=1: discard rdata, issue (pc_src_e ? pc_target_e : redir_pc), go to WAIT.
- DROP, with rvalid=0 and pc_src_e=1: redir_pc<=pc_target_e, stay in DROP.

IF/ID register update priority (per cycle):
1. rst
2. flush_d: NOP_INSTR, valid_d=0, pc_d/pc_plus4_d unchanged
3. stall_d: hold all
4. deliver: instr_d=data, pc_d=pc, pc_plus4_d=pc+4, valid_d=1
5. otherwise bubble: instr_d=NOP_INSTR, valid_d=0

Additional rules:
- A redirect never delivers in the same cycle. The hazard unit asserts flush_d alongside pc_src_e.
- Addresses wrap modulo 2^DATA_WIDTH; no alignment checking.

Test Plan:
1. Reset, then a latency-1 memory returning 0xAAAA0000+addr: imem_addr = 0,4,8,... on consecutive cycles. IF/ID shows pc_d 0,4,8 with valid_d=1 every cycle from cycle 2, and pc_plus4_d = pc_d+4.
2. Latency-3 memory: one request every 3 cycles. valid_d=1 for 1 cycle in 3; other cycles show instr_d=0x00000013 with valid_d=0.
3. Latency 1, stall_d held high for 2 cycles exactly when the response for 0x8 arrives: the FSM enters HOLD, imem_req=0 and IF/ID holds. On release, pc_d=0x8 with the correct instr, and the next request goes to 0xC.
4. Latency 3, pc_src_e=1 with target 0x100 one cycle after the request to 0x4: the 0x4 response is discarded, the next imem_addr=0x100, and pc_d=0x4 never appears with valid_d=1.
5. pc_src_e=1 (target 0x200) in the same cycle as rvalid: the same cycle shows imem_req=1 with imem_addr=0x200. Also, a second redirect to 0x300 while in DROP produces a next request to 0x300.
6. rst asserted mid-WAIT (memory model also reset): the next cycle shows all outputs at reset values and state IDLE, then imem_addr=RESET_PC.
